// File: rtl/imem_if.sv
// ============================================================================
// imem_if : instruction-memory read bus (request / response)
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

interface imem_if #(
  parameter int XLEN = 32
);
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_rvalid;
  logic [31:0]     imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rvalid,
    output imem_rdata
  );
endinterface

`default_nettype wire

// File: rtl/instr_fetch_unit.sv
// ============================================================================
// instr_fetch_unit : PC, single-outstanding imem fetch, instruction FIFO.
// Optional FETCH_PERF_CNT_EN adds fetched_cnt / dropped_cnt outputs.
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module instr_fetch_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              DEPTH    = 2
) (
  input  wire logic            clk,
  input  wire logic            rst_n,
  input  wire logic            stall,
  input  wire logic            redirect,
  input  wire logic [XLEN-1:0] redirect_pc,
  imem_if.master               imem,
  output logic [31:0]          Ins,
  output logic                 en,
  output logic [XLEN-1:0]      pc_out
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]          fetched_cnt,
  output logic [31:0]          dropped_cnt
`endif
);

  localparam int               PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int               CNT_W   = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   req_pc_q, req_pc_d;
  logic [PTR_W-1:0]  wptr_q, wptr_d;
  logic [PTR_W-1:0]  rptr_q, rptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [31:0]       ins_mem_q [DEPTH];
  logic [XLEN-1:0]   pc_mem_q  [DEPTH];

  logic issue;
  logic push;
  logic pop;
  logic discard;
  logic empty;

  assign empty          = (count_q == '0);
  assign en             = !empty && !redirect;
  assign pop            = en && !stall;
  assign Ins            = empty ? 32'd0 : ins_mem_q[rptr_q];
  assign pc_out         = empty ? '0 : pc_mem_q[rptr_q];
  assign imem.imem_req  = issue;
  assign imem.imem_addr = pc_q;

  // Fetch sequencer: one request in flight, response dropped if a redirect
  // intervened between request and response.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    req_pc_d = req_pc_q;
    issue    = 1'b0;
    push     = 1'b0;
    discard  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (rst_n && !redirect && (count_q < DEPTH_C)) begin
          issue    = 1'b1;
          req_pc_d = pc_q;
          pc_d     = pc_q + XLEN'(4);
          state_d  = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem.imem_rvalid) begin
          push    = !redirect;
          discard = redirect;
          state_d = S_IDLE;
        end else if (redirect) begin
          state_d = S_DROP;
        end
      end
      S_DROP: begin
        if (imem.imem_rvalid) begin
          discard = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (redirect) begin
      pc_d = redirect_pc & ~(XLEN'(3));
    end
  end

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (redirect) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (push) wptr_d = wptr_q + PTR_W'(1);
      if (pop)  rptr_d = rptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      pc_q     <= RESET_PC;
      req_pc_q <= '0;
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only visible while count_q covers them.
  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      ins_mem_q[wptr_q] <= imem.imem_rdata;
      pc_mem_q[wptr_q]  <= req_pc_q;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetched_cnt_q;
  logic [31:0] dropped_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetched_cnt_q <= 32'd0;
      dropped_cnt_q <= 32'd0;
    end else begin
      fetched_cnt_q <= fetched_cnt_q + 32'(push);
      dropped_cnt_q <= dropped_cnt_q + 32'(discard)
                       + (redirect ? 32'(count_q) : 32'd0);
    end
  end

  assign fetched_cnt = fetched_cnt_q;
  assign dropped_cnt = dropped_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
// ============================================================================
// tb_instr_fetch_unit : randomized fetch traffic against a queue-based model.
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_instr_fetch_unit;

  localparam int DEPTH = 2;
  localparam int NCYC  = 4000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] Ins;
  logic        en;
  logic [31:0] pc_out;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetched_cnt;
  logic [31:0] dropped_cnt;
`endif

  always #5 clk = ~clk;

  imem_if #(.XLEN(32)) bus ();

  instr_fetch_unit #(
    .XLEN     (32),
    .RESET_PC (32'h0000_0000),
    .DEPTH    (DEPTH)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem        (bus),
    .Ins         (Ins),
    .en          (en),
    .pc_out      (pc_out)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetched_cnt (fetched_cnt),
    .dropped_cnt (dropped_cnt)
`endif
  );

  int          vecs = 0;
  int          fails = 0;
  int          pops = 0;
  ent_t        sbq[$];
  logic        pend = 1'b0;
  logic        pend_killed = 1'b0;
  logic [31:0] pend_addr = 32'd0;
  logic [31:0] pend_data = 32'd0;
  int          pend_due = 0;
  logic [31:0] exp_pc = 32'd0;
  int unsigned fetched_m = 0;
  int unsigned dropped_m = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Instruction memory contents: two fixed words at 0/4, hashed elsewhere.
  function automatic logic [31:0] memfn(input logic [31:0] a);
    if (a == 32'h0) return 32'h415A04B3;
    if (a == 32'h4) return 32'h015A0493;
    return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction

  // Stimulus, memory responder and model of request/redirect/response rules.
  initial begin
    logic exp_req;
    int   lat;
    rst_n       = 1'b0;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'd0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = 32'd0;
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(posedge clk);
      if (!rst_n) begin
        sbq.delete();
        pend      = 1'b0;
        exp_pc    = 32'h0000_0000;
        fetched_m = 0;
        dropped_m = 0;
      end else begin
        if (redirect) begin
          dropped_m += sbq.size();
          sbq.delete();
        end
        if (bus.imem_rvalid) begin
          if (pend_killed) dropped_m++;
          else begin
            sbq.push_back('{pc: pend_addr, ins: pend_data});
            fetched_m++;
          end
          pend = 1'b0;
        end
      end

      #1;
      rst_n = !(cyc < 2 || cyc == 30 || cyc == 31);
      lat   = 1;
      if (cyc < 32) begin
        stall = 1'b0; redirect = 1'b0;
      end else if (cyc < 42) begin
        stall = 1'b1; redirect = 1'b0;
      end else if (cyc < 60 || cyc >= NCYC - 40) begin
        stall = 1'b0; redirect = 1'b0;
        if (cyc >= 60) lat = $urandom_range(1, 4);
      end else begin
        stall    = ($urandom_range(0, 9) < 3);
        redirect = ($urandom_range(0, 15) == 0);
        lat      = $urandom_range(1, 4);
      end
      if (redirect) begin
        case ($urandom_range(0, 3))
          0:       redirect_pc = 32'hFFFF_FFFC;
          1:       redirect_pc = 32'h0000_0103;
          2:       redirect_pc = 32'hFFFF_FFF6;
          default: redirect_pc = $urandom;
        endcase
        if (pend) pend_killed = 1'b1;
      end
      bus.imem_rvalid = pend && (cyc == pend_due);
      bus.imem_rdata  = bus.imem_rvalid ? pend_data : $urandom;

      #1;
      exp_req = rst_n && !redirect && !pend && (sbq.size() < DEPTH);
      check("imem_req", {31'd0, bus.imem_req}, {31'd0, exp_req});
      if (bus.imem_req) begin
        check("imem_addr", bus.imem_addr, exp_pc);
        pend        = 1'b1;
        pend_killed = 1'b0;
        pend_addr   = exp_pc;
        pend_data   = memfn(exp_pc);
        pend_due    = cyc + lat;
        exp_pc      = exp_pc + 32'd4;
      end
      if (redirect) exp_pc = redirect_pc & ~32'h3;
`ifdef FETCH_PERF_CNT_EN
      check("fetched_cnt", fetched_cnt, fetched_m);
      check("dropped_cnt", dropped_cnt, dropped_m);
`endif
    end
    check("pops_seen", {31'd0, (pops > 100)}, 32'd1);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end

  // Monitor: decoder-side outputs against the expected FIFO contents.
  initial begin
    logic r;
    logic exp_en;
    forever begin
      @(posedge clk);
      r = rst_n;
      @(negedge clk);
      if (!r) begin
        check("rst_en", {31'd0, en}, 32'd0);
        check("rst_Ins", Ins, 32'd0);
        check("rst_pc_out", pc_out, 32'd0);
      end else begin
        exp_en = (sbq.size() != 0) && !redirect;
        check("en", {31'd0, en}, {31'd0, exp_en});
        if (sbq.size() != 0) begin
          check("Ins", Ins, sbq[0].ins);
          check("pc_out", pc_out, sbq[0].pc);
          if (exp_en && !stall) begin
            void'(sbq.pop_front());
            pops++;
          end
        end else begin
          check("Ins_empty", Ins, 32'd0);
          check("pc_out_empty", pc_out, 32'd0);
        end
      end
    end
  end

endmodule

`default_nettype wire
